// File: rtl/uart_cmd_if.sv
// Byte-in / command-out bundle between the UART receiver,
// the command assembler and the command processor.
interface uart_cmd_if;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        timeout;

  modport master (
    output rx_data,
    output rx_rdy,
    output clr_cmd_rdy,
    input  clr_rx_rdy,
    input  cmd,
    input  cmd_rdy,
    input  timeout
  );

  modport slave (
    input  rx_data,
    input  rx_rdy,
    input  clr_cmd_rdy,
    output clr_rx_rdy,
    output cmd,
    output cmd_rdy,
    output timeout
  );
endinterface

// File: rtl/uart_cmd_assembler.sv
// Pairs two UART bytes (high first) into a 16-bit command,
// discarding a lone high byte when the low byte is late.
module uart_cmd_assembler #(
  parameter int unsigned TIMEOUT_CYC = 26040
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_cmd_if.slave bus
);

  localparam int unsigned CW =
    (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(TIMEOUT_CYC - 1);

  typedef enum logic {
    IDLE,
    HIGH
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    hi_byte;
  logic [CW-1:0] cnt;
  logic [15:0]   cmd_q;
  logic          cmd_rdy_q;
  logic          hi_acc;
  logic          lo_acc;
  logic          to_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.rx_rdy) begin
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (bus.rx_rdy || cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A byte arriving in the terminal cycle beats the timeout.
  always_comb begin
    hi_acc = 1'b0;
    lo_acc = 1'b0;
    to_hit = 1'b0;
    unique case (state)
      IDLE: hi_acc = bus.rx_rdy;
      HIGH: begin
        lo_acc = bus.rx_rdy;
        to_hit = !bus.rx_rdy && cnt == CNT_LAST;
      end
      default: ;
    endcase
    if (!rst_n) begin
      hi_acc = 1'b0;
      lo_acc = 1'b0;
      to_hit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_byte   <= 8'h00;
      cmd_q     <= 16'h0000;
      cmd_rdy_q <= 1'b0;
      cnt       <= '0;
    end else begin
      if (hi_acc) begin
        hi_byte <= bus.rx_data;
      end else if (to_hit) begin
        hi_byte <= 8'h00;
      end
      if (lo_acc) begin
        cmd_q <= {hi_byte, bus.rx_data};
      end
      if (lo_acc) begin
        cmd_rdy_q <= 1'b1;
      end else if (bus.clr_cmd_rdy || hi_acc) begin
        cmd_rdy_q <= 1'b0;
      end
      if (state == HIGH && state_nxt == HIGH) begin
        cnt <= (cnt == CNT_LAST) ? cnt : cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

  assign bus.clr_rx_rdy = hi_acc | lo_acc;
  assign bus.timeout    = to_hit;
  assign bus.cmd        = cmd_q;
  assign bus.cmd_rdy    = cmd_rdy_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Directed bench for the UART command assembler using a
// short timeout window so expiry paths run quickly.
module tb_uart_cmd_assembler;

  localparam int unsigned TC = 16;

  logic clk;
  logic rst_n;
  int   n_asrt;
  int   n_fail;
  int   pulses;
  int   where;

  uart_cmd_if bus ();

  uart_cmd_assembler #(
    .TIMEOUT_CYC(TC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Receiver model: holds rdy until the cleared edge.
  task automatic put(input logic [7:0] b, input string tag);
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    #1;
    chk({tag, "_clr"}, 16'(bus.clr_rx_rdy), 16'd1);
    @(posedge clk);
    #1;
    bus.rx_rdy = 1'b0;
    #1;
    chk({tag, "_clr_drop"}, 16'(bus.clr_rx_rdy), 16'd0);
  endtask

  initial begin
    n_asrt = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.rx_data = 8'h77;
    bus.rx_rdy = 1'b1;
    bus.clr_cmd_rdy = 1'b0;
    tick();
    tick();
    chk("rst_cmd", bus.cmd, 16'h0000);
    chk("rst_cmd_rdy", 16'(bus.cmd_rdy), 16'd0);
    chk("rst_timeout", 16'(bus.timeout), 16'd0);
    chk("rst_clr_rx", 16'(bus.clr_rx_rdy), 16'd0);
    bus.rx_rdy = 1'b0;
    rst_n = 1'b1;
    tick();

    put(8'hA5, "t1_hi");
    chk("t1_mid_rdy", 16'(bus.cmd_rdy), 16'd0);
    put(8'h3C, "t1_lo");
    chk("t1_cmd", bus.cmd, 16'hA53C);
    chk("t1_rdy", 16'(bus.cmd_rdy), 16'd1);

    bus.clr_cmd_rdy = 1'b1;
    tick();
    bus.clr_cmd_rdy = 1'b0;
    chk("t2_rdy", 16'(bus.cmd_rdy), 16'd0);
    chk("t2_cmd", bus.cmd, 16'hA53C);

    put(8'h12, "t3_hi");
    pulses = 0;
    where = -1;
    for (int i = 0; i < int'(TC) + 3; i++) begin
      if (bus.timeout) begin
        pulses++;
        where = i;
      end
      tick();
    end
    chk("t3_pulses", 16'(pulses), 16'd1);
    chk("t3_when", 16'(where), 16'(TC - 1));
    chk("t3_cmd_kept", bus.cmd, 16'hA53C);
    put(8'h34, "t3_hi2");
    put(8'h56, "t3_lo2");
    chk("t3_cmd", bus.cmd, 16'h3456);
    chk("t3_rdy", 16'(bus.cmd_rdy), 16'd1);

    put(8'h9A, "t4_hi");
    chk("t4_hi_clears_rdy", 16'(bus.cmd_rdy), 16'd0);
    chk("t4_cmd_kept", bus.cmd, 16'h3456);
    pulses = 0;
    for (int i = 0; i < int'(TC) - 1; i++) begin
      if (bus.timeout) pulses++;
      tick();
    end
    chk("t4_no_early_to", 16'(pulses), 16'd0);
    bus.rx_data = 8'hBC;
    bus.rx_rdy = 1'b1;
    #1;
    chk("t4_to_last", 16'(bus.timeout), 16'd0);
    chk("t4_clr_last", 16'(bus.clr_rx_rdy), 16'd1);
    tick();
    bus.rx_rdy = 1'b0;
    #1;
    chk("t4_cmd", bus.cmd, 16'h9ABC);
    chk("t4_rdy", 16'(bus.cmd_rdy), 16'd1);
    chk("t4_to_after", 16'(bus.timeout), 16'd0);

    put(8'h11, "t5_hi");
    chk("t5_hi_clears_rdy", 16'(bus.cmd_rdy), 16'd0);
    bus.clr_cmd_rdy = 1'b1;
    put(8'h22, "t5_lo");
    bus.clr_cmd_rdy = 1'b0;
    chk("t5_set_wins", 16'(bus.cmd_rdy), 16'd1);
    chk("t5_cmd", bus.cmd, 16'h1122);

    put(8'hFF, "t6_hi");
    rst_n = 1'b0;
    bus.rx_data = 8'h77;
    bus.rx_rdy = 1'b1;
    #1;
    chk("t6_clr_in_rst", 16'(bus.clr_rx_rdy), 16'd0);
    tick();
    chk("t6_rdy_rst", 16'(bus.cmd_rdy), 16'd0);
    chk("t6_cmd_rst", bus.cmd, 16'h0000);
    bus.rx_rdy = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("t6_rdy_post", 16'(bus.cmd_rdy), 16'd0);
    put(8'h01, "t6_hi2");
    chk("t6_rdy_mid", 16'(bus.cmd_rdy), 16'd0);
    put(8'h02, "t6_lo2");
    chk("t6_cmd", bus.cmd, 16'h0102);
    chk("t6_rdy", 16'(bus.cmd_rdy), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
